// File: rtl/bit_pixel_streamer.sv
// Double-buffered bit-image reader. Streams NUM_REGIONS packed-bit RAMs as
// lane-expanded words over valid/ready, with start/end-of-region sideband.
//
// state | meaning
// IDLE  | waiting for image_number to differ from the latched tag
// READ  | issuing RAM reads, one per cycle while credits remain
// DRAIN | all reads issued, waiting for in-flight reads and FIFO to empty
module bit_pixel_streamer #(
    parameter int         SIDE_WIDTH   = 240,
    parameter int         CENTER_WIDTH = 304,
    parameter int         HEIGHT       = 480,
    parameter int         NUM_REGIONS  = 3,
    parameter logic [7:0] CENTER_MASK  = 8'b0000_0010,
    parameter int         PIX_PER_WORD = 8,
    parameter int         OUT_BITS     = 8,
    parameter int         RD_LATENCY   = 1,
    parameter int         ADDR_W       = 16
) (
    input  logic                              pclk,
    input  logic                              pclk_reset,
    input  logic [3:0]                        image_number,
    output logic [ADDR_W-1:0]                 rd_address,
    input  logic [NUM_REGIONS*PIX_PER_WORD-1:0] rd_data,
    output logic [PIX_PER_WORD*OUT_BITS-1:0]  bit_pixels,
    output logic                              pixels_valid,
    input  logic                              pixels_ready,
    output logic                              pixels_sop,
    output logic                              pixels_eop,
    output logic [2:0]                        region_index,
    output logic                              busy,
    output logic                              buf_index,
    output logic                              frame_done
);
    // FIFO holds every read that can be in flight plus two so a full-rate
    // stream never bubbles.
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] region;
        logic       sop;
        logic       eop;
    } tag_t;

    typedef struct packed {
        logic [2:0]              region;
        logic                    sop;
        logic                    eop;
        logic [PIX_PER_WORD-1:0] data;
    } entry_t;

    function automatic logic [ADDR_W-1:0] words_of(input logic [2:0] r);
        int w;
        w = CENTER_MASK[r] ? CENTER_WIDTH : SIDE_WIDTH;
        return ADDR_W'((w * HEIGHT) / PIX_PER_WORD);
    endfunction

    // Buffer half 1 of each region sits directly above half 0.
    function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] r, input logic b);
        return b ? words_of(r) : '0;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          img_q, img_d;
    logic                buf_q, buf_d;
    logic [2:0]          region_q, region_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    tag_t                tag_q [RD_LATENCY];
    tag_t                tag_d [RD_LATENCY];
    entry_t              mem_q [FIFO_DEPTH];
    entry_t              mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [CNT_W-1:0]    inflight;
    logic [CNT_W:0]      occupancy;
    logic                credit_ok, push, pop, done_c;
    logic [PIX_PER_WORD-1:0] wr_word;
    logic [ADDR_W-1:0]   last_addr;

    // Next-state: read issue, tag pipeline, FIFO bookkeeping and frame FSM.
    always_comb begin
        state_d  = state_q;
        img_d    = img_q;
        buf_d    = buf_q;
        region_d = region_q;
        addr_d   = addr_q;
        tag_d    = tag_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        done_c   = 1'b0;
        wr_word  = '0;

        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(tag_q[i].vld);
        end
        occupancy = {1'b0, count_q} + {1'b0, inflight};
        credit_ok = (occupancy < DEPTH_C);
        last_addr = base_of(region_q, buf_q) + words_of(region_q) - ADDR_W'(1);

        // Returning data is steered by the tag that travelled with its read.
        push = tag_q[RD_LATENCY-1].vld;
        pop  = (count_q != '0) && pixels_ready;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (tag_q[RD_LATENCY-1].region == 3'(r)) begin
                wr_word = rd_data[r*PIX_PER_WORD +: PIX_PER_WORD];
            end
        end
        if (push) begin
            mem_d[wr_ptr_q] = '{region: tag_q[RD_LATENCY-1].region,
                                sop:    tag_q[RD_LATENCY-1].sop,
                                eop:    tag_q[RD_LATENCY-1].eop,
                                data:   wr_word};
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        tag_d[0] = '0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (image_number != img_q) begin
                    img_d    = image_number;
                    region_d = '0;
                    addr_d   = base_of(3'd0, buf_q);
                    state_d  = READ;
                end
            end
            READ: begin
                if (credit_ok) begin
                    tag_d[0] = '{vld:    1'b1,
                                 region: region_q,
                                 sop:    (addr_q == base_of(region_q, buf_q)),
                                 eop:    (addr_q == last_addr)};
                    if (addr_q == last_addr) begin
                        if (region_q == 3'(NUM_REGIONS-1)) begin
                            state_d = DRAIN;
                        end else begin
                            region_d = region_q + 3'd1;
                            addr_d   = base_of(region_q + 3'd1, buf_q);
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((count_q == '0) && (inflight == '0)) begin
                    done_c  = 1'b1;
                    buf_d   = ~buf_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, tag pipeline and FIFO registers.
    always_ff @(posedge pclk or posedge pclk_reset) begin
        if (pclk_reset) begin
            state_q  <= IDLE;
            img_q    <= '0;
            buf_q    <= 1'b0;
            region_q <= '0;
            addr_q   <= '0;
            tag_q    <= '{default: '0};
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            img_q    <= img_d;
            buf_q    <= buf_d;
            region_q <= region_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    entry_t head;
    assign head         = mem_q[rd_ptr_q];
    assign pixels_valid = (count_q != '0);
    assign pixels_sop   = pixels_valid & head.sop;
    assign pixels_eop   = pixels_valid & head.eop;
    assign region_index = pixels_valid ? head.region : 3'd0;
    assign rd_address   = addr_q;
    assign busy         = (state_q != IDLE);
    assign buf_index    = buf_q;
    assign frame_done   = done_c;

    // Each pixel bit becomes the MSB of its own OUT_BITS lane, lane 0 lowest.
    always_comb begin
        bit_pixels = '0;
        for (int i = 0; i < PIX_PER_WORD; i++) begin
            bit_pixels[i*OUT_BITS + OUT_BITS - 1] = pixels_valid & head.data[i];
        end
    end
endmodule

// File: doc/bit_pixel_streamer.md
# bit_pixel_streamer

Parametrised, double-buffered reader that streams 1-bit census/threshold pixels out of NUM_REGIONS packed-bit RAMs. Each frame streams the regions in index order as lane-expanded words over a true valid/ready handshake, and tolerates any RAM read latency. A start-of-region and end-of-region sideband replaces the all-ones first-word sentinel. The block sits between the bit-image RAMs and the block-matching cost pipeline.

## Interface
- SIDE_WIDTH, 240: pixel width of a side region.
- CENTER_WIDTH, 304: pixel width of a center region.
- HEIGHT, 480: rows per region.
- NUM_REGIONS, 3: regions streamed per frame (1..8).
- CENTER_MASK, 3'b010: bit r set means region r uses CENTER_WIDTH.
- PIX_PER_WORD, 8: bits per RAM word.
- OUT_BITS, 8: output lane width per pixel (at least 1).
- RD_LATENCY, 1: cycles from rd_address to valid rd_data (1..4).
- ADDR_W, 16: RAM address width.
- Legality: width*HEIGHT must be divisible by PIX_PER_WORD for each region width, and 2*words(region) must not exceed 2^ADDR_W.

Ports:
- pclk, in, 1: clock.
- pclk_reset, in, 1: reset, asynchronous, active-high.
- image_number, in, 4: frame tag; any change requests a frame.
- rd_address, out, ADDR_W: shared address to all region RAMs.
- rd_data, in, NUM_REGIONS*PIX_PER_WORD: region r occupies slice [r*PIX_PER_WORD +: PIX_PER_WORD].
- bit_pixels, out, PIX_PER_WORD*OUT_BITS: expanded word.
- pixels_valid, out, 1: output word valid.
- pixels_ready, in, 1: consumer accepts.
- pixels_sop / pixels_eop, out, 1: first / last word of a region, qualified by valid.
- region_index, out, 3: region of the current output word.
- busy, out, 1: high when state is not IDLE.
- buf_index, out, 1: buffer half read by the current or next frame.
- frame_done, out, 1: one-cycle pulse.

## Operation
- words(r) = (CENTER_MASK[r] ? CENTER_WIDTH : SIDE_WIDTH) * HEIGHT / PIX_PER_WORD.
- Region r base address = buf_index ? words(r) : 0. The address runs from base to base + words(r) - 1.

States:
- IDLE:
  - If image_number != image_number_reg, latch image_number_reg, set region = 0 and address = base(0), and go to READ.
- READ:
  - Issue one read per cycle while credits > 0.
  - Credits = FIFO_DEPTH - fifo_count - inflight, with FIFO_DEPTH = RD_LATENCY + 2.
  - Each issue pushes a tag {region, sop, eop} into a RD_LATENCY-deep shift register.
  - After the last address of a region, advance to region + 1 at base(region + 1).
  - After the last address of region NUM_REGIONS-1, go to DRAIN.
- DRAIN:
  - When the FIFO is empty, inflight = 0, and no handshake remains, go to IDLE.
  - In that same cycle, pulse frame_done and toggle buf_index.

Datapath and handshake:
- When a tag emerges, the matching slice of rd_data is written into the FIFO together with the tag.
- The FIFO head drives the output.
- Expansion: output lane i = {rd_word[i], (OUT_BITS-1)'b0}, with lane 0 in the LSBs.
- Valid/ready rules:
  - pixels_valid never drops without a handshake.
  - bit_pixels, sop, eop and region_index are stable while valid is high and ready is low.
  - A transfer happens on a cycle where valid and ready are both high.
- The FIFO never overflows, because credits cover all in-flight reads. Issue stalls only on credits.
- image_number changes during READ or DRAIN are not latched.
  - Because the compare still mismatches on return to IDLE, the next frame starts one cycle later.
  - Multiple changes collapse into one frame.
- The image_number_reg reset value is 0, so a tag of 0 after reset starts nothing.

## Timing
- Reset values:
  - rd_address = 0, bit_pixels = 0, pixels_valid = 0, sop = 0, eop = 0, region_index = 0.
  - busy = 0, buf_index = 0, frame_done = 0.
  - FIFO empty, inflight = 0, state IDLE, image_number_reg = 0.
- Reset asserted mid-frame clears everything at once; valid drops with no handshake.
- Start latency, taking the change as visible in cycle 0:
  - Cycle 1: READ, rd_address = base(0).
  - Cycle 1+RD_LATENCY: FIFO write.
  - Cycle 2+RD_LATENCY: pixels_valid = 1.
- With ready held high, throughput is 1 word per cycle, with no bubbles at region boundaries.
- Total words per frame = sum of words(r).
- frame_done comes 1 cycle after the final handshake, when the FIFO has drained. The next frame's reads use the toggled buffer half.
- Backpressure: once ready goes low, at most RD_LATENCY + 2 words are buffered. Issue stops within one cycle.

## Test plan
Common parameters: SIDE_WIDTH=16, CENTER_WIDTH=24, HEIGHT=2, RD_LATENCY=1. This gives side words = 4 and center words = 6.

1. Basic frame:
   - Stimulus: image_number 0→1, ready held high.
   - Required: 14 words.
   - Addresses: 0–3, then 0–5, then 0–3.
   - sop at words 0, 4 and 10; eop at words 3, 9 and 13.
   - First valid in cycle 3; frame_done once; buf_index → 1.
2. Second frame:
   - Stimulus: image_number 1→2.
   - Required: addresses 4–7, 6–11, 4–7; buf_index → 0 afterwards.
3. Lane expansion:
   - Stimulus: RAM word 8'b1000_0001 from region 1.
   - Required: bit_pixels = 64'h8000_0000_0000_0080 and region_index = 1.
4. Random backpressure:
   - Stimulus: ready random at 30%, RD_LATENCY = 3.
   - Required:
     - Word order and contents match the model.
     - Output held stable while stalled.
     - FIFO never exceeds depth 5.
     - Exactly 14 handshakes.
5. Mid-frame tag changes:
   - Stimulus: image_number changes twice during READ.
   - Required:
     - The current frame completes.
     - Exactly one extra frame starts 1 cycle after returning to IDLE.
     - That frame reads the toggled buffer half.
6. Reset mid-frame:
   - Stimulus: assert pclk_reset at word 7 while ready is low.
   - Required:
     - Valid goes to 0 immediately.
     - State is IDLE and buf_index = 0.
     - A following 0→1 change restarts from address 0.
